// File: rtl/decode_pkg.sv
// decode_pkg: shared types and field positions for the instruction decode stage.
// The op 00 immediate rotation is selected by the DECODE_ROT_IMM_EN macro
// inside instr_field_decode; this package is identical in both builds.
package decode_pkg;

  // Major opcode classes taken from instr[27:26]
  typedef enum logic [1:0] {
    DP  = 2'b00,
    MEM = 2'b01,
    BR  = 2'b10,
    ILL = 2'b11
  } op_e;

  // Occupancy of the OUT/SKID register pair
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } skid_state_e;

  // Decoded fields held in OUT and SKID. The immediate is kept at 32 bits;
  // imm_sext tells the output stage to sign-extend it to DATA_WIDTH.
  typedef struct packed {
    op_e         op;
    logic [3:0]  cond;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [3:0]  rd;
    logic [31:0] imm;
    logic        imm_sext;
    logic [1:0]  sh_type;
    logic [4:0]  shamt;
    logic        idx_pre;
    logic        idx_up;
    logic        idx_wb;
    logic        link;
    logic        illegal;
  } decoded_t;

  // Instruction field bit positions
  localparam int COND_LSB   = 28;
  localparam int OP_LSB     = 26;
  localparam int I_BIT      = 25;
  localparam int FUNCT_LSB  = 20;
  localparam int RN_LSB     = 16;
  localparam int RD_LSB     = 12;
  localparam int ROT_LSB    = 8;
  localparam int SHAMT_LSB  = 7;
  localparam int SHTYPE_LSB = 5;
  localparam int RM_LSB     = 0;
  localparam int IMM8_LSB   = 0;
  localparam int IMM12_LSB  = 0;
  localparam int P_BIT      = 24;
  localparam int U_BIT      = 23;
  localparam int W_BIT      = 21;
  localparam int L_BIT      = 24;
  localparam int BOFF_MSB   = 23;

  // 32-bit rotate right; amounts 0..31
  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
    logic [63:0] t;
    t = {v, v} >> amt;
    return t[31:0];
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// instr_field_decode: purely combinational split of a 32-bit instruction into
// decoded_t. Macro DECODE_ROT_IMM_EN enables rotation of op 00 immediates;
// without it the 8-bit immediate is zero-extended and instr[11:8] ignored.
// Branch offsets are sign-extended and shifted within 32 bits, which keeps the
// full value as long as BRANCH_SHIFT <= 8.
module instr_field_decode
  import decode_pkg::*;
#(
  parameter int BRANCH_SHIFT = 2
) (
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [31:0] dp_imm;
  logic [31:0] br_off;

`ifdef DECODE_ROT_IMM_EN
  assign dp_imm = ror32({24'b0, instr[IMM8_LSB +: 8]}, {instr[ROT_LSB +: 4], 1'b0});
`else
  assign dp_imm = {24'b0, instr[IMM8_LSB +: 8]};
`endif

  assign br_off = {{8{instr[BOFF_MSB]}}, instr[BOFF_MSB:0]};

  // Field extraction per op class; anything not set for a class stays zero
  always_comb begin
    dec      = '0;
    dec.op   = op_e'(instr[OP_LSB +: 2]);
    dec.cond = instr[COND_LSB +: 4];
    unique case (op_e'(instr[OP_LSB +: 2]))
      DP: begin
        dec.funct = instr[FUNCT_LSB +: 6];
        dec.rn    = instr[RN_LSB +: 4];
        dec.rd    = instr[RD_LSB +: 4];
        if (instr[I_BIT]) begin
          dec.imm = dp_imm;
        end else begin
          dec.rm      = instr[RM_LSB +: 4];
          dec.shamt   = instr[SHAMT_LSB +: 5];
          dec.sh_type = instr[SHTYPE_LSB +: 2];
        end
      end
      MEM: begin
        dec.funct   = instr[FUNCT_LSB +: 6];
        dec.rn      = instr[RN_LSB +: 4];
        dec.rd      = instr[RD_LSB +: 4];
        dec.idx_pre = instr[P_BIT];
        dec.idx_up  = instr[U_BIT];
        dec.idx_wb  = instr[W_BIT];
        if (!instr[I_BIT]) begin
          dec.imm = {20'b0, instr[IMM12_LSB +: 12]};
        end else begin
          dec.rm      = instr[RM_LSB +: 4];
          dec.shamt   = instr[SHAMT_LSB +: 5];
          dec.sh_type = instr[SHTYPE_LSB +: 2];
        end
      end
      BR: begin
        dec.funct    = {4'b0, instr[I_BIT], instr[L_BIT]};
        dec.link     = instr[L_BIT];
        dec.imm      = br_off << BRANCH_SHIFT;
        dec.imm_sext = 1'b1;
      end
      ILL: begin
        dec.illegal = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered decode stage with a two-entry skid buffer
// (OUT + SKID) so fetch and execute can stall independently. in_ready is a
// register equal to (state != FULL). Optional macro DECODE_ROT_IMM_EN is
// handled inside instr_field_decode. DATA_WIDTH must be at least 32.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_W        = 4,
  parameter int BRANCH_SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            op,
  output logic [3:0]            cond,
  output logic [5:0]            funct,
  output logic [REG_W-1:0]      rn,
  output logic [REG_W-1:0]      rm,
  output logic [REG_W-1:0]      rd,
  output logic [DATA_WIDTH-1:0] imm,
  output logic [1:0]            sh_type,
  output logic [4:0]            shamt,
  output logic                  idx_pre,
  output logic                  idx_up,
  output logic                  idx_wb,
  output logic                  link,
  output logic                  illegal
);

  decoded_t              dec;
  decoded_t              out_q;
  decoded_t              skid_q;
  skid_state_e           state;
  logic                  accept;
  logic                  deliver;
  logic [DATA_WIDTH-1:0] imm_signed;
  logic [DATA_WIDTH-1:0] imm_unsigned;

  instr_field_decode #(
    .BRANCH_SHIFT(BRANCH_SHIFT)
  ) u_field_decode (
    .instr(instr),
    .dec  (dec)
  );

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  // Skid buffer state machine: flush beats accept/deliver, SKID drains into OUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_q     <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_q     <= '0;
      skid_q    <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            out_q     <= dec;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && !deliver) begin
            skid_q   <= dec;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (!accept && deliver) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end else if (accept && deliver) begin
            out_q <= dec;
          end
        end
        FULL: begin
          if (deliver) begin
            out_q    <= skid_q;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= EMPTY;
        end
      endcase
    end
  end

  assign imm_signed   = DATA_WIDTH'($signed(out_q.imm));
  assign imm_unsigned = DATA_WIDTH'(out_q.imm);

  assign op      = out_q.op;
  assign cond    = out_q.cond;
  assign funct   = out_q.funct;
  assign rn      = REG_W'(out_q.rn);
  assign rm      = REG_W'(out_q.rm);
  assign rd      = REG_W'(out_q.rd);
  assign imm     = out_q.imm_sext ? imm_signed : imm_unsigned;
  assign sh_type = out_q.sh_type;
  assign shamt   = out_q.shamt;
  assign idx_pre = out_q.idx_pre;
  assign idx_up  = out_q.idx_up;
  assign idx_wb  = out_q.idx_wb;
  assign link    = out_q.link;
  assign illegal = out_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed vectors against a queue-based reference of
// the decode stage, plus literal checks of key decodes and flow-control cases.
// Honours DECODE_ROT_IMM_EN for the rotated-immediate expectations.
module tb_instr_decode_stage;

  localparam int DATA_WIDTH   = 32;
  localparam int REG_W        = 4;
  localparam int BRANCH_SHIFT = 2;

  logic                  clk;
  logic                  rst_n;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           instr;
  logic                  out_valid;
  logic                  out_ready;
  logic [1:0]            op;
  logic [3:0]            cond;
  logic [5:0]            funct;
  logic [REG_W-1:0]      rn;
  logic [REG_W-1:0]      rm;
  logic [REG_W-1:0]      rd;
  logic [DATA_WIDTH-1:0] imm;
  logic [1:0]            sh_type;
  logic [4:0]            shamt;
  logic                  idx_pre;
  logic                  idx_up;
  logic                  idx_wb;
  logic                  link;
  logic                  illegal;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] exp_q[$];
  bit          model_acc;
  bit          model_del;
  logic [67:0] dut_fields;

  instr_decode_stage #(
    .DATA_WIDTH  (DATA_WIDTH),
    .REG_W       (REG_W),
    .BRANCH_SHIFT(BRANCH_SHIFT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr    (instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .op       (op),
    .cond     (cond),
    .funct    (funct),
    .rn       (rn),
    .rm       (rm),
    .rd       (rd),
    .imm      (imm),
    .sh_type  (sh_type),
    .shamt    (shamt),
    .idx_pre  (idx_pre),
    .idx_up   (idx_up),
    .idx_wb   (idx_wb),
    .link     (link),
    .illegal  (illegal)
  );

  assign dut_fields = {op, cond, funct, rn, rm, rd, imm, sh_type, shamt,
                       idx_pre, idx_up, idx_wb, link, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode written straight from the field rules
  function automatic logic [67:0] ref_decode(input logic [31:0] w);
    logic [1:0]  f_op;
    logic [3:0]  f_cond, f_rn, f_rm, f_rd;
    logic [5:0]  f_funct;
    logic [31:0] f_imm;
    logic [1:0]  f_sht;
    logic [4:0]  f_sa;
    logic        f_p, f_u, f_w, f_l, f_ill;
    int          off;
    int          rot;
    f_op = w[27:26]; f_cond = w[31:28];
    f_rn = '0; f_rm = '0; f_rd = '0; f_funct = '0; f_imm = '0; f_sht = '0; f_sa = '0;
    f_p = 0; f_u = 0; f_w = 0; f_l = 0; f_ill = 0;
    if (f_op == 2'd0) begin
      f_funct = w[25:20]; f_rn = w[19:16]; f_rd = w[15:12];
      if (w[25]) begin
        f_imm = {24'b0, w[7:0]};
`ifdef DECODE_ROT_IMM_EN
        rot = 2 * int'(w[11:8]);
        for (int k = 0; k < rot; k++) f_imm = {f_imm[0], f_imm[31:1]};
`else
        rot = 0;
`endif
      end else begin
        f_rm = w[3:0]; f_sa = w[11:7]; f_sht = w[6:5];
      end
    end else if (f_op == 2'd1) begin
      f_funct = w[25:20]; f_rn = w[19:16]; f_rd = w[15:12];
      f_p = w[24]; f_u = w[23]; f_w = w[21];
      if (!w[25]) f_imm = {20'b0, w[11:0]};
      else begin
        f_rm = w[3:0]; f_sa = w[11:7]; f_sht = w[6:5];
      end
    end else if (f_op == 2'd2) begin
      f_funct = {4'b0, w[25:24]};
      f_l     = w[24];
      off     = int'($signed(w[23:0]));
      off     = off * (1 << BRANCH_SHIFT);
      f_imm   = off;
    end else begin
      f_ill = 1'b1;
    end
    return {f_op, f_cond, f_funct, f_rn, f_rm, f_rd, f_imm, f_sht, f_sa,
            f_p, f_u, f_w, f_l, f_ill};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] w,
                               input logic r, input logic f);
    @(posedge clk);
    #1;
    in_valid  = v;
    instr     = w;
    out_ready = r;
    flush     = f;
  endtask

  // Reference queue: up to two words in flight, cleared by reset or flush
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else begin
      model_acc = in_valid && (exp_q.size() < 2);
      model_del = (exp_q.size() > 0) && out_ready;
      if (model_del) void'(exp_q.pop_front());
      if (model_acc) exp_q.push_back(instr);
    end
  end

  // Per-cycle comparison of handshake and fields against the reference
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
      checkOutput("rst_fields", 128'(dut_fields), 128'(0));
    end else begin
      checkOutput("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
      checkOutput("in_ready", 128'(in_ready), 128'(exp_q.size() < 2));
      if (exp_q.size() > 0)
        checkOutput("fields", 128'(dut_fields), 128'(ref_decode(exp_q[0])));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] vec [8];
    logic        rdy [8];
    logic [2:0]  idx;
    vec = '{32'hE0812003, 32'hE1A00102, 32'hE5912004, 32'hE7912103,
            32'hEB000010, 32'hE3A0F4FF, 32'hFC000000, 32'hE2411001};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b0; flush = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
    checkOutput("reset_in_ready", 128'(in_ready), 128'(1));

    $display("[TB] MOV immediate");
    applyStimulus(1'b1, 32'hE3A010FF, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("mov_valid", 128'(out_valid), 128'(1));
    checkOutput("mov_op", 128'(op), 128'(0));
    checkOutput("mov_funct", 128'(funct), 128'(6'h3A));
    checkOutput("mov_rd", 128'(rd), 128'(1));
    checkOutput("mov_rn", 128'(rn), 128'(0));
    checkOutput("mov_imm", 128'(imm), 128'(32'h000000FF));

    $display("[TB] rotated immediate");
    applyStimulus(1'b1, 32'hE3A014FF, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
`ifdef DECODE_ROT_IMM_EN
    checkOutput("rot_imm", 128'(imm), 128'(32'hFF000000));
`else
    checkOutput("rot_imm", 128'(imm), 128'(32'h000000FF));
`endif

    $display("[TB] branch");
    applyStimulus(1'b1, 32'hEAFFFFFE, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("br_op", 128'(op), 128'(2));
    checkOutput("br_funct", 128'(funct), 128'(6'h02));
    checkOutput("br_link", 128'(link), 128'(0));
    checkOutput("br_imm", 128'(imm), 128'(32'hFFFFFFF8));

    $display("[TB] illegal op");
    applyStimulus(1'b1, 32'hFC000000, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("ill_flag", 128'(illegal), 128'(1));
    checkOutput("ill_op_cond", 128'({op, cond}), 128'(6'h3F));
    checkOutput("ill_zero_fields",
                128'({funct, rn, rm, rd, imm, sh_type, shamt, idx_pre, idx_up, idx_wb, link}),
                128'(0));

    $display("[TB] backpressure");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hE3A01001, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hE3A02002, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hE3A03003, 1'b0, 1'b0);
    checkOutput("bp_full_in_ready", 128'(in_ready), 128'(0));
    checkOutput("bp_full_rd", 128'(rd), 128'(1));
    applyStimulus(1'b1, 32'hE3A03003, 1'b1, 1'b0);
    checkOutput("bp_hold_in_ready", 128'(in_ready), 128'(0));
    checkOutput("bp_hold_rd", 128'(rd), 128'(1));
    applyStimulus(1'b1, 32'hE3A03003, 1'b1, 1'b0);
    checkOutput("bp_second_rd", 128'(rd), 128'(2));
    checkOutput("bp_second_in_ready", 128'(in_ready), 128'(1));
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("bp_third_rd", 128'(rd), 128'(3));
    checkOutput("bp_third_valid", 128'(out_valid), 128'(1));
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("bp_drained", 128'(out_valid), 128'(0));

    $display("[TB] flush while full");
    applyStimulus(1'b1, 32'hE3A01001, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hE3A02002, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hE3A07007, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("flush_out_valid", 128'(out_valid), 128'(0));
    checkOutput("flush_in_ready", 128'(in_ready), 128'(1));
    applyStimulus(1'b1, 32'hE3A08008, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("post_flush_rd", 128'(rd), 128'(8));

    $display("[TB] flush drops input");
    applyStimulus(1'b1, 32'hE3A01001, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hE3A07007, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("flush_one_out_valid", 128'(out_valid), 128'(0));
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] stream with stalls");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, vec[i], rdy[i], 1'b0);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] mixed traffic");
    for (int i = 0; i < 60; i++) begin
      idx = 3'($urandom_range(0, 7));
      applyStimulus(1'($urandom_range(0, 1)), vec[idx], 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 15) == 0));
    end
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] reset while full");
    applyStimulus(1'b1, 32'hE5912004, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hEB000010, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("pre_reset_full", 128'({out_valid, in_ready}), 128'(2'b10));
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", 128'(out_valid), 128'(0));
    checkOutput("async_reset_fields", 128'(dut_fields), 128'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("after_reset_in_ready", 128'(in_ready), 128'(1));
    applyStimulus(1'b1, 32'hE2411001, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("after_reset_imm", 128'(imm), 128'(32'h1));
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("final_empty", 128'(out_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered, flow-controlled instruction decode stage for the 32-bit ARM-style core, sitting between fetch and register read. Splits each instruction into op/cond/funct/register/immediate fields, adds rotated data-processing immediates, sign-extended branch offsets, shift and index-mode fields, and an illegal-op flag. A two-entry skid buffer lets fetch and execute stall independently.

## Interface
- DATA_WIDTH, 32 — width of `imm` output; must be ≥ 32.
- REG_W, 4 — register index width.
- BRANCH_SHIFT, 2 — left shift applied to the branch offset.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  fetch presents `instr`.
- in_ready  out  1  stage can accept; registered.
- instr  in  32  instruction word.
- out_valid  out  1  decoded fields valid.
- out_ready  in  1  execute accepts.
- op  out  2  `instr[27:26]`.
- cond  out  4  `instr[31:28]`.
- funct  out  6  function field (see Operation).
- rn, rm, rd  out  REG_W each  first operand, second operand, destination.
- imm  out  DATA_WIDTH  immediate.
- sh_type  out  2  register shift type.
- shamt  out  5  register shift amount.
- idx_pre, idx_up, idx_wb  out  1 each  memory P/U/W bits.
- link  out  1  branch-with-link.
- illegal  out  1  op = 11.

## Operation
- Accept when `in_valid && in_ready`. Deliver when `out_valid && out_ready`.
- Unless stated otherwise below, every decoded field is 0.
- `I = instr[25]`.
- **op 00 (data processing):**
  - `funct=instr[25:20]`, `rn=[19:16]`, `rd=[15:12]`.
  - I=1: `imm = {24'b0,[7:0]}` rotated right by `2*[11:8]` in 32 bits, then zero-extended to DATA_WIDTH. `rm=0`.
  - I=0: `rm=[3:0]`, `shamt=[11:7]`, `sh_type=[6:5]`, `imm=0`.
- **op 01 (memory):**
  - `funct=[25:20]`, `rn`, `rd` as above.
  - `idx_pre=[24]`, `idx_up=[23]`, `idx_wb=[21]`.
  - I=0: `imm` = zero-extended `[11:0]`, `rm=0`.
  - I=1: `rm=[3:0]`, `shamt`, `sh_type`, `imm=0`.
- **op 10 (branch):**
  - `funct={4'b0,[25:24]}`, `link=[24]`, `rn=rm=rd=0`.
  - `imm` = sign-extend `[23:0]` to DATA_WIDTH, then `<< BRANCH_SHIFT`.
- **op 11:** `illegal=1`, all other fields 0, `op`/`cond` still passed through.
- **Storage:**
  - Output register (OUT) plus skid register (SKID), each with a valid bit.
  - States: EMPTY (OUT invalid), ONE (OUT valid, SKID empty), FULL (both valid).
  - EMPTY: accept → ONE.
  - ONE: accept without deliver → FULL. Deliver without accept → EMPTY. Both together → ONE with the new word in OUT.
  - FULL: `in_ready=0`. Deliver → ONE, with SKID moving to OUT.
  - Order is strictly preserved; no word is lost or duplicated.
- **flush:** next cycle EMPTY, `out_valid=0`, `in_ready=1`. An input presented during the flush cycle is dropped.
- **Reset values:** `out_valid=0`, `in_ready=1` (after release), all field outputs 0, state EMPTY. Reset asserted mid-stream discards both entries immediately.

## Timing
- Latency: accept at edge N → `out_valid` and fields visible after edge N (one cycle).
- `in_ready` is registered: `in_ready = (state != FULL)`, with no combinational path from `out_ready`.
- Throughput: 1 instruction/cycle while `out_ready=1`.
- Outputs are stable while `out_valid && !out_ready`.
- flush has priority over accept and deliver in the same cycle.

## Configuration
- `DECODE_ROT_IMM_EN` defined: op 00 immediates rotated as above.
- Undefined: op 00 immediate is zero-extended `[7:0]` with no rotation and `[11:8]` ignored. All other behaviour is identical.

## Structure
- Package `decode_pkg`:
  - `op_e` enum (DP, MEM, BR, ILL).
  - `decoded_t` packed struct of all field outputs.
  - `skid_state_e` enum.
  - Field bit-position localparams.
- One sub-module, `instr_field_decode`: purely combinational `instr → decoded_t`, carrying the macro-dependent logic.
- `instr_decode_stage` holds only the OUT/SKID registers and the state machine.

## Test plan
- `0xE3A010FF`, out_ready=1 → next cycle op=00, funct=0x3A, rd=1, rn=0, imm=0x000000FF.
- `0xE3A014FF` → imm=0xFF000000 with `DECODE_ROT_IMM_EN`, 0x000000FF without.
- `0xEAFFFFFE` → op=10, funct=0x02, link=0, imm=0xFFFFFFF8.
- Backpressure:
  - Stimulus: out_ready=0, feed A, B, C on consecutive cycles, then release out_ready.
  - Response: A and B accepted, in_ready=0 while C is held. After release, A, B, C delivered in order on consecutive cycles.
- flush with state FULL plus a word on the input → next cycle out_valid=0, in_ready=1. The dropped word never appears.
- Bad op and mid-stream reset:
  - `0xFC000000` → illegal=1, all other fields 0.
  - rst_n pulsed low while FULL → out_valid=0 asynchronously and all fields 0.
